// File: rtl/row_map_loader_if.sv
// Host-side bundle for the row remap table loader: run control, FIFO read port,
// table write port and run status.
interface row_map_loader_if #(
    parameter int unsigned DEPTH = 512
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic          start;
    logic          mode;
    logic [AW-1:0] start_addr;
    logic [CW-1:0] count;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [15:0]   fifo_dout;
    logic [AW-1:0] mem_write_addr;
    logic [AW-1:0] mem_write_data;
    logic          mem_write_en;
    logic          busy;
    logic          done;
    logic [CW-1:0] written;

    // Host / FIFO / table side.
    modport master (
        output start, mode, start_addr, count, fifo_empty, fifo_dout,
        input  fifo_rd_en, mem_write_addr, mem_write_data, mem_write_en,
               busy, done, written
    );

    // Loader side.
    modport slave (
        input  start, mode, start_addr, count, fifo_empty, fifo_dout,
        output fifo_rd_en, mem_write_addr, mem_write_data, mem_write_en,
               busy, done, written
    );
endinterface

// File: rtl/row_map_loader.sv
// Write-side sequencer for the row address remap table: paced single-cycle write
// strobes fed either by an identity ramp or by a 1-cycle-latency host FIFO.
module row_map_loader #(
    parameter int unsigned WR_GAP = 3,
    parameter int unsigned DEPTH  = 512
) (
    input logic             clk,
    input logic             rst,
    row_map_loader_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned GW = $clog2(WR_GAP + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_WRITE,
        S_GAP,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic          mode_q, mode_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] written_q, written_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] data_q, data_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          wr_en_q, wr_en_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          fifo_rd_c;
    logic          gap_last;
    logic          unused_dout_bits;

    assign gap_last         = (gap_q == GW'(WR_GAP - 1));
    assign unused_dout_bits = ^bus.fifo_dout[15:AW];

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mode_q    <= 1'b0;
            count_q   <= '0;
            written_q <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            gap_q     <= '0;
            wr_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            count_q   <= count_d;
            written_q <= written_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            gap_q     <= gap_d;
            wr_en_q   <= wr_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.count == '0) state_d = S_DONE;
                    else if (bus.mode)   state_d = S_FETCH;
                    else                 state_d = S_WRITE;
                end
            end
            S_FETCH:   if (!bus.fifo_empty) state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_WRITE;
            S_WRITE:   state_d = S_GAP;
            S_GAP: begin
                if (gap_last) begin
                    if (written_q == count_q) state_d = S_DONE;
                    else if (mode_q)          state_d = S_FETCH;
                    else                      state_d = S_WRITE;
                end
            end
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Datapath and output logic; address/data only move on entry to WRITE or on
    // the last gap cycle, so they are stable for the whole strobe.
    always_comb begin
        mode_d    = mode_q;
        count_d   = count_q;
        written_d = written_q;
        addr_d    = addr_q;
        data_d    = data_q;
        gap_d     = '0;
        fifo_rd_c = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mode_d    = bus.mode;
                    count_d   = bus.count;
                    addr_d    = bus.start_addr;
                    written_d = '0;
                    if (state_d == S_WRITE) data_d = bus.start_addr;
                end
            end
            S_FETCH:   fifo_rd_c = !bus.fifo_empty;
            S_CAPTURE: data_d = bus.fifo_dout[AW-1:0];
            S_WRITE:   written_d = written_q + CW'(1);
            S_GAP: begin
                gap_d = gap_last ? '0 : gap_q + GW'(1);
                if (gap_last) begin
                    addr_d = addr_q + AW'(1);
                    if (state_d == S_WRITE) data_d = addr_q + AW'(1);
                end
            end
            default: ;
        endcase
        wr_en_d = (state_d == S_WRITE);
        busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d  = (state_d == S_DONE);
    end

    assign bus.fifo_rd_en     = fifo_rd_c & ~rst;
    assign bus.mem_write_addr = addr_q;
    assign bus.mem_write_data = data_q;
    assign bus.mem_write_en   = wr_en_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.written        = written_q;
endmodule

// File: tb/tb_row_map_loader.sv
// Scoreboard bench for row_map_loader: a run-level reference model queues the
// expected strobes and done pulse, an independent monitor checks them.
module tb_row_map_loader;
    localparam int unsigned WR_GAP = 3;

    typedef struct { int unsigned cyc; int addr; int data; } wr_t;
    typedef struct { int unsigned cyc; int written; } dn_t;
    typedef struct { logic [15:0] w; int unsigned avail; } fe_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned cyc = 0;

    row_map_loader_if #(.DEPTH(512)) bus ();

    row_map_loader #(.WR_GAP(WR_GAP), .DEPTH(512)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    wr_t  exp_wr[$];
    dn_t  exp_done[$];
    fe_t  fifo_q[$];
    logic [15:0] stim_words[$];
    int          stim_offs[$];
    logic [8:0]  table_mem [512];
    int n_cmp = 0;
    int n_bad = 0;
    int rd_cnt = 0;
    int exp_rd = 0;
    int strobe_cnt = 0;
    logic [15:0] pend_word = '0;
    bit          have_pend = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // FIFO model: 1-cycle read latency, junk on dout when no word was just read.
    initial begin
        bus.fifo_empty = 1'b1;
        bus.fifo_dout  = '0;
        forever begin
            @(negedge clk);
            if (have_pend) begin
                bus.fifo_dout = pend_word;
                have_pend = 0;
            end else begin
                bus.fifo_dout = 16'($urandom);
            end
            #1;
            bus.fifo_empty = (fifo_q.size() == 0) || (fifo_q[0].avail > cyc);
            #1;
            if (bus.fifo_rd_en && !bus.fifo_empty && !rst) begin
                pend_word = fifo_q[0].w;
                void'(fifo_q.pop_front());
                have_pend = 1;
            end
        end
    end

    // Monitor: compares every strobe and done pulse against the scoreboard.
    initial begin
        wr_t e;
        dn_t d;
        forever begin
            @(negedge clk);
            #3;
            if (!rst) begin
                if (bus.fifo_rd_en) begin
                    rd_cnt++;
                    chk("rd_en_while_empty", int'(bus.fifo_empty), 0);
                end
                if (bus.mem_write_en) begin
                    strobe_cnt++;
                    table_mem[bus.mem_write_addr] = bus.mem_write_data;
                    if (exp_wr.size() == 0) begin
                        chk("spurious_strobe", int'(bus.mem_write_en), 0);
                    end else begin
                        e = exp_wr.pop_front();
                        chk("strobe_cycle", int'(cyc), int'(e.cyc));
                        chk("strobe_addr", int'(bus.mem_write_addr), e.addr);
                        chk("strobe_data", int'(bus.mem_write_data), e.data);
                        chk("busy_at_strobe", int'(bus.busy), 1);
                    end
                end
                if (bus.done) begin
                    if (exp_done.size() == 0) begin
                        chk("spurious_done", int'(bus.done), 0);
                    end else begin
                        d = exp_done.pop_front();
                        chk("done_cycle", int'(cyc), int'(d.cyc));
                        chk("done_written", int'(bus.written), d.written);
                        chk("busy_at_done", int'(bus.busy), 0);
                    end
                end
            end
        end
    end

    // Reference model for one run, from the documented timing rules.
    task automatic launch(input bit m, input int sa, input int cnt);
        int unsigned t, tf, ts, r, av;
        wr_t e;
        fe_t f;
        dn_t d;
        @(negedge clk);
        t  = cyc;
        tf = t + 1;
        ts = t;
        for (int k = 0; k < cnt; k++) begin
            e.addr = (sa + k) % 512;
            if (m) begin
                av = t + stim_offs[k];
                r  = (tf > av) ? tf : av;
                ts = r + 2;
                tf = ts + WR_GAP + 1;
                e.data  = int'(stim_words[k][8:0]);
                f.w     = stim_words[k];
                f.avail = av;
                fifo_q.push_back(f);
            end else begin
                ts = t + 1 + k * (WR_GAP + 1);
                e.data = e.addr;
            end
            e.cyc = ts;
            exp_wr.push_back(e);
        end
        d.cyc     = (cnt == 0) ? t + 1 : ts + WR_GAP + 1;
        d.written = cnt;
        exp_done.push_back(d);
        exp_rd = m ? cnt : 0;
        rd_cnt = 0;
        bus.start      = 1'b1;
        bus.mode       = m;
        bus.start_addr = 9'(sa);
        bus.count      = 10'(cnt);
        @(negedge clk);
        bus.start      = 1'b0;
        bus.mode       = 1'($urandom);
        bus.start_addr = 9'($urandom);
        bus.count      = 10'($urandom);
    endtask

    task automatic finish_run(input int budget);
        int n = 0;
        while ((exp_wr.size() + exp_done.size()) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("run_complete", exp_wr.size() + exp_done.size(), 0);
        repeat (WR_GAP + 4) @(negedge clk);
        chk("fifo_reads", rd_cnt, exp_rd);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_fifo_rd_en"}, int'(bus.fifo_rd_en), 0);
        chk({tag, "_wr_addr"}, int'(bus.mem_write_addr), 0);
        chk({tag, "_wr_data"}, int'(bus.mem_write_data), 0);
        chk({tag, "_wr_en"}, int'(bus.mem_write_en), 0);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_done"}, int'(bus.done), 0);
        chk({tag, "_written"}, int'(bus.written), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int o;
        bus.start = 1'b0;
        bus.mode = 1'b0;
        bus.start_addr = '0;
        bus.count = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #3;
        chk_outputs_zero("reset");

        // Identity fill of the whole table, then readback.
        launch(1'b0, 0, 512);
        finish_run(2200);
        for (int r = 0; r < 512; r++) chk("readback", int'(table_mem[r]), r);

        // Stream load with upper FIFO bits set.
        stim_words = '{16'h01FF, 16'h0005, 16'hFE07};
        stim_offs  = '{0, 0, 0};
        launch(1'b1, 10, 3);
        finish_run(100);

        // Second word arrives after a 5-cycle empty stretch in FETCH.
        stim_words = '{16'h0123, 16'h0ABC};
        stim_offs  = '{0, 12};
        launch(1'b1, 200, 2);
        finish_run(100);

        // Address wrap and zero count.
        launch(1'b0, 510, 4);
        finish_run(100);
        launch(1'b0, 77, 0);
        finish_run(20);

        // Reset after the second strobe of a 10-entry run.
        launch(1'b0, 40, 10);
        n = 0;
        while (strobe_cnt < 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        strobe_cnt = 0;
        rst = 1'b1;
        exp_wr.delete();
        exp_done.delete();
        @(negedge clk);
        rst = 1'b0;
        #3;
        chk_outputs_zero("midrun_reset");
        launch(1'b0, 300, 5);
        finish_run(100);

        // A start pulse during GAP must be ignored.
        launch(1'b0, 100, 6);
        @(negedge clk);
        bus.start      = 1'b1;
        bus.mode       = 1'b1;
        bus.start_addr = 9'd333;
        bus.count      = 10'd1;
        @(negedge clk);
        bus.start = 1'b0;
        finish_run(100);

        // Randomized runs.
        for (int i = 0; i < 10; i++) begin
            int unsigned cnt;
            bit m;
            m   = 1'($urandom);
            cnt = (i == 4) ? 0 : $urandom_range(1, 12);
            stim_words.delete();
            stim_offs.delete();
            o = 0;
            for (int k = 0; k < int'(cnt); k++) begin
                stim_words.push_back(16'($urandom));
                o += $urandom_range(0, 6);
                stim_offs.push_back(o);
            end
            launch(m, $urandom_range(0, 511), int'(cnt));
            finish_run(400);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
